// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT types, Q1.15 constants and saturation helper
package fft_pkg;

  localparam int DW = 16;
  localparam int Q  = 15;

  // Half an LSB of Q1.15 in the 33-bit product domain.
  localparam logic signed [32:0] ROUND_Q15 = 33'sd16384;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  // Clamp a wide signed value to the 16-bit Q1.15 range.
  function automatic logic signed [DW-1:0] sat16(input logic signed [32:0] x);
    if (x > 33'sd32767) begin
      return 16'sh7FFF;
    end else if (x < -33'sd32768) begin
      return 16'sh8000;
    end else begin
      return x[DW-1:0];
    end
  endfunction

endpackage

// File: rtl/fft_butterfly_if.sv
// rtl/fft_butterfly_if.sv - operand, twiddle and result bundle for the butterfly
interface fft_butterfly_if;
  import fft_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_index;
  logic signed [DW-1:0] a_re;
  logic signed [DW-1:0] a_im;
  logic signed [DW-1:0] b_re;
  logic signed [DW-1:0] b_im;
  logic [2:0]           tw_index;
  logic signed [DW-1:0] tw_re;
  logic signed [DW-1:0] tw_im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] x0_re;
  logic signed [DW-1:0] x0_im;
  logic signed [DW-1:0] x1_re;
  logic signed [DW-1:0] x1_im;

  modport slave (
    input  in_valid, in_index, a_re, a_im, b_re, b_im, tw_re, tw_im, out_ready,
    output in_ready, tw_index, out_valid, x0_re, x0_im, x1_re, x1_im
  );

  modport master (
    output in_valid, in_index, a_re, a_im, b_re, b_im, tw_re, tw_im, out_ready,
    input  in_ready, tw_index, out_valid, x0_re, x0_im, x1_re, x1_im
  );

endinterface

// File: rtl/cmul_q15.sv
// rtl/cmul_q15.sv - combinational Q1.15 complex multiply with rounding and saturation
module cmul_q15
  import fft_pkg::*;
(
  input  cplx_t a,
  input  cplx_t b,
  output cplx_t p
);

  logic signed [DW-1:0]   ar, ai, br, bi;
  logic signed [2*DW-1:0] rr, ii, ri, ir;
  logic signed [32:0]     re_full, im_full;

  // Four full-precision products, combined in 33 bits, rounded half-up and clamped.
  always_comb begin
    ar      = a.re;
    ai      = a.im;
    br      = b.re;
    bi      = b.im;
    rr      = ar * br;
    ii      = ai * bi;
    ri      = ar * bi;
    ir      = ai * br;
    re_full = {rr[2*DW-1], rr} - {ii[2*DW-1], ii} + ROUND_Q15;
    im_full = {ri[2*DW-1], ri} + {ir[2*DW-1], ir} + ROUND_Q15;
    p.re    = sat16(re_full >>> Q);
    p.im    = sat16(im_full >>> Q);
  end

endmodule

// File: rtl/fft_butterfly.sv
// rtl/fft_butterfly.sv - 3-stage radix-2 DIT butterfly; FFT_BFLY_SCALE_EN selects 1/2 output scaling
module fft_butterfly
  import fft_pkg::*;
(
  input logic            clk,
  input logic            rst,
  fft_butterfly_if.slave bif
);

  logic       en;
  cplx_t      tw_w, p_w;
  cplx_t      s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  cplx_t      s2_a_q, s2_a_d, s2_p_q, s2_p_d;
  cplx_t      x0_q, x0_d, x1_q, x1_d;
  logic [2:0] s1_index_q, s1_index_d;
  logic       v1_q, v1_d, v2_q, v2_d, out_valid_q, out_valid_d;
  logic signed [DW:0] sum_re, sum_im, dif_re, dif_im;

`ifdef FFT_BFLY_SCALE_EN
  // Halve with round-half-up; the 17-bit sum always lands inside 16 bits.
  function automatic logic signed [DW-1:0] narrow(input logic signed [DW:0] x);
    return DW'((x + 17'sd1) >>> 1);
  endfunction
`else
  // Keep full scale and clamp on overflow.
  function automatic logic signed [DW-1:0] narrow(input logic signed [DW:0] x);
    return sat16({{(32-DW){x[DW]}}, x});
  endfunction
`endif

  // The whole pipeline advances together; only a held output stalls it.
  assign en            = !out_valid_q || bif.out_ready;
  assign bif.in_ready  = en;
  // During a stall the ROM keeps re-reading the S1 index so its data stays aligned with S1.
  assign bif.tw_index  = en ? bif.in_index : s1_index_q;
  assign bif.out_valid = out_valid_q;
  assign bif.x0_re     = x0_q.re;
  assign bif.x0_im     = x0_q.im;
  assign bif.x1_re     = x1_q.re;
  assign bif.x1_im     = x1_q.im;
  assign tw_w          = {bif.tw_re, bif.tw_im};

  cmul_q15 u_cmul (
    .a (s1_b_q),
    .b (tw_w),
    .p (p_w)
  );

  // Next-state for all three stages: hold by default, load on advance.
  always_comb begin
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_index_d  = s1_index_q;
    v1_d        = v1_q;
    s2_a_d      = s2_a_q;
    s2_p_d      = s2_p_q;
    v2_d        = v2_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    out_valid_d = out_valid_q;
    sum_re      = {s2_a_q.re[DW-1], s2_a_q.re} + {s2_p_q.re[DW-1], s2_p_q.re};
    sum_im      = {s2_a_q.im[DW-1], s2_a_q.im} + {s2_p_q.im[DW-1], s2_p_q.im};
    dif_re      = {s2_a_q.re[DW-1], s2_a_q.re} - {s2_p_q.re[DW-1], s2_p_q.re};
    dif_im      = {s2_a_q.im[DW-1], s2_a_q.im} - {s2_p_q.im[DW-1], s2_p_q.im};
    if (en) begin
      s1_a_d      = {bif.a_re, bif.a_im};
      s1_b_d      = {bif.b_re, bif.b_im};
      s1_index_d  = bif.in_index;
      v1_d        = bif.in_valid;
      s2_a_d      = s1_a_q;
      s2_p_d      = p_w;
      v2_d        = v1_q;
      x0_d.re     = narrow(sum_re);
      x0_d.im     = narrow(sum_im);
      x1_d.re     = narrow(dif_re);
      x1_d.im     = narrow(dif_im);
      out_valid_d = v2_q;
    end
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_index_q  <= '0;
      v1_q        <= 1'b0;
      s2_a_q      <= '0;
      s2_p_q      <= '0;
      v2_q        <= 1'b0;
      x0_q        <= '0;
      x1_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_index_q  <= s1_index_d;
      v1_q        <= v1_d;
      s2_a_q      <= s2_a_d;
      s2_p_q      <= s2_p_d;
      v2_q        <= v2_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fft_butterfly.sv
// tb/tb_fft_butterfly.sv - scoreboard bench for fft_butterfly with a twiddle ROM model
module tb_fft_butterfly;
  import fft_pkg::*;

  typedef struct {
    logic [15:0] x0r, x0i, x1r, x1i;
    int          idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  bit   rnd_done;

  // W8^k = exp(-j*2*pi*k/8) in Q1.15
  int wre[8] = '{32767, 23170, 0, -23170, -32768, -23170, 0, 23170};
  int wim[8] = '{0, -23170, -32768, -23170, 0, 23170, 32767, 23170};

  fft_butterfly_if bif ();

  fft_butterfly u_dut (
    .clk (clk),
    .rst (rst),
    .bif (bif.slave)
  );

  always #5 clk = ~clk;

  // Registered twiddle ROM
  always @(posedge clk) begin
    bif.tw_re <= 16'(wre[bif.tw_index]);
    bif.tw_im <= 16'(wim[bif.tw_index]);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int clamp16(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int q15(longint v);
    return clamp16((v + 64'sd16384) >>> 15);
  endfunction

  function automatic int out_ref(int s);
`ifdef FFT_BFLY_SCALE_EN
    return (s + 1) >>> 1;
`else
    return clamp16(longint'(s));
`endif
  endfunction

  function automatic exp_t model(int idx, int ar, int ai, int br, int bi);
    exp_t e;
    int pr, pi;
    pr = q15(longint'(br) * wre[idx] - longint'(bi) * wim[idx]);
    pi = q15(longint'(br) * wim[idx] + longint'(bi) * wre[idx]);
    e.x0r = 16'(out_ref(ar + pr));
    e.x0i = 16'(out_ref(ai + pi));
    e.x1r = 16'(out_ref(ar - pr));
    e.x1i = 16'(out_ref(ai - pi));
    e.idx = idx;
    return e;
  endfunction

  function automatic exp_t mk(int idx, logic [15:0] a, logic [15:0] b, logic [15:0] c, logic [15:0] d);
    exp_t e;
    e.x0r = a; e.x0i = b; e.x1r = c; e.x1i = d; e.idx = idx;
    return e;
  endfunction

  function automatic int rnd16();
    logic signed [15:0] t;
    t = 16'($urandom);
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present one butterfly and hold it until accepted; push its expected result on accept.
  task automatic drive(int idx, int ar, int ai, int br, int bi, exp_t e);
    bif.in_valid = 1'b1;
    bif.in_index = 3'(idx);
    bif.a_re = 16'(ar); bif.a_im = 16'(ai);
    bif.b_re = 16'(br); bif.b_im = 16'(bi);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bif.in_ready) begin
        sb.push_back(e);
        return;
      end
      step();
    end
    checks++; errors++;
    $display("FAIL drive_timeout: in_ready stayed 0 for index %0d", idx);
    bif.in_valid = 1'b0;
  endtask

  task automatic drive_rnd(int idx);
    int ar, ai, br, bi;
    ar = rnd16(); ai = rnd16(); br = rnd16(); bi = rnd16();
    drive(idx, ar, ai, br, bi, model(idx, ar, ai, br, bi));
  endtask

  // Called right after an accept with an empty pipeline behind it.
  task automatic lat_check(string name);
    step();
    bif.in_valid = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk({name, "_early"}, bif.out_valid, 0);
    step();
    @(negedge clk);
    chk({name, "_valid"}, bif.out_valid, 1);
    step();
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || bif.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL %s_drain: %0d results still pending", name, sb.size());
    end
    step();
  endtask

  // Scoreboard monitor: compare each result as it is handed off.
  always @(negedge clk) begin
    if (!rst && bif.out_valid && bif.out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got %h%h%h%h with nothing expected",
                 bif.x0_re, bif.x0_im, bif.x1_re, bif.x1_im);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("result_idx%0d", mon_e.idx),
            {bif.x0_re, bif.x0_im, bif.x1_re, bif.x1_im},
            {mon_e.x0r, mon_e.x0i, mon_e.x1r, mon_e.x1i});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e1, e2, e3;
    logic [63:0] snap;
    bit vin[11];
`ifdef FFT_BFLY_SCALE_EN
    e1 = mk(0, 16'h3000, 16'h0000, 16'h1000, 16'h0000);
    e2 = mk(2, 16'h2000, 16'hF000, 16'h2000, 16'h1000);
    e3 = mk(0, 16'h7000, 16'h0000, 16'h0001, 16'h0000);
`else
    e1 = mk(0, 16'h6000, 16'h0000, 16'h2000, 16'h0000);
    e2 = mk(2, 16'h4000, 16'hE000, 16'h4000, 16'h2000);
    e3 = mk(0, 16'h7FFF, 16'h0000, 16'h0001, 16'h0000);
`endif
    bif.in_valid = 1'b0; bif.in_index = 3'd5; bif.out_ready = 1'b1;
    bif.a_re = '0; bif.a_im = '0; bif.b_re = '0; bif.b_im = '0;

    // Reset state
    #12;
    chk("rst_out_valid", bif.out_valid, 0);
    chk("rst_in_ready", bif.in_ready, 1);
    chk("rst_outputs", {bif.x0_re, bif.x0_im, bif.x1_re, bif.x1_im}, 64'h0);
    chk("rst_tw_index", bif.tw_index, 5);
    #1 rst = 1'b0;
    step();

    // Directed: identity twiddle, -j twiddle, overflow
    drive(0, 16'h4000, 0, 16'h2000, 0, e1);
    lat_check("lat_idx0");
    drain("idx0");
    drive(2, 16'h4000, 0, 16'h2000, 0, e2);
    chk("tw_index_accept", bif.tw_index, 2);
    step(); bif.in_valid = 1'b0;
    drain("idx2");
    drive(0, 16'h7000, 0, 16'h7000, 0, e3);
    step(); bif.in_valid = 1'b0;
    drain("ovf");

    // Backpressure: four back-to-back items, output held for three cycles
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          drive_rnd(k);
          step();
        end
        bif.in_valid = 1'b0;
        bif.in_index = 3'd7;
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!bif.out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("bp_first_output", bif.out_valid, 1);
        step();
        bif.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("stall_in_ready", bif.in_ready, 0);
          chk("stall_tw_index", bif.tw_index, 3);
          if (c == 0) snap = {bif.x0_re, bif.x0_im, bif.x1_re, bif.x1_im};
          else chk("stall_hold", {bif.x0_re, bif.x0_im, bif.x1_re, bif.x1_im}, snap);
        end
        step();
        bif.out_ready = 1'b1;
      end
    join
    drain("bp");

    // Reset mid-stream: one result held at the output, two more in flight
    bif.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_rnd(k + 4);
      step();
    end
    bif.in_valid = 1'b0;
    chk("pre_rst_valid", bif.out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bif.out_valid, 0);
    chk("mid_rst_outputs", {bif.x0_re, bif.x0_im, bif.x1_re, bif.x1_im}, 64'h0);
    sb.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    bif.out_ready = 1'b1;
    chk("post_rst_in_ready", bif.in_ready, 1);
    step();
    drive_rnd(1);
    lat_check("lat_after_rst");
    drain("rst");

    // Bubbles: alternate valid, out_valid must follow two edges later
    for (int i = 0; i < 11; i++) begin
      vin[i] = (i < 8) && (i % 2 == 0);
      bif.in_valid = vin[i];
      bif.in_index = 3'($urandom_range(0, 7));
      bif.a_re = 16'(rnd16()); bif.a_im = 16'(rnd16());
      bif.b_re = 16'(rnd16()); bif.b_im = 16'(rnd16());
      @(negedge clk);
      if (vin[i] && bif.in_ready)
        sb.push_back(model(int'(bif.in_index), int'(bif.a_re), int'(bif.a_im),
                           int'(bif.b_re), int'(bif.b_im)));
      if (i >= 3) chk("bubble_valid", bif.out_valid, vin[i-3]);
      step();
    end
    bif.in_valid = 1'b0;
    drain("bubble");

    // Random stream with random gaps and random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          int gap;
          gap = $urandom_range(0, 2);
          bif.in_valid = 1'b0;
          for (int g = 0; g < gap; g++) step();
          drive_rnd($urandom_range(0, 7));
          step();
        end
        bif.in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        int n;
        n = 0;
        while (!rnd_done && n < 2000) begin
          step();
          bif.out_ready = ($urandom_range(0, 3) != 0);
          n++;
        end
      end
    join
    bif.out_ready = 1'b1;
    drain("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_butterfly.md
# fft_butterfly

Pipelined radix-2 decimation-in-time butterfly for the 8-point FFT datapath. It sits directly downstream of `twiddleROM`: it drives the ROM's 3-bit index and consumes the registered `Wreal`/`Wimag` one clock later. From operands A and B it computes X0 = A + B·W and X1 = A − B·W in Q1.15 fixed point. It uses a valid/ready handshake, so the FFT stage controller can stream butterflies back-to-back and stall on downstream backpressure.

## Interface
- `DW`, 16: sample/twiddle width, signed Q1.15; only 16 is supported.
- `clk` in 1: single clock; all registers and the ROM are clocked on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input operands and index are valid.
- `in_ready` out 1: block accepts input this cycle.
- `in_index` in 3: twiddle index k for W8^k.
- `a_re`, `a_im`, `b_re`, `b_im` in DW each: operands A and B.
- `tw_index` out 3: index to `twiddleROM`.
- `tw_re`, `tw_im` in DW: `Wreal`/`Wimag` from `twiddleROM`, registered inside the ROM.
- `out_valid` out 1: X0/X1 valid.
- `out_ready` in 1: downstream accepts the output.
- `x0_re`, `x0_im`, `x1_re`, `x1_im` out DW: butterfly results.

## Operation
- Global advance enable: `en = !out_valid || out_ready`. `in_ready = en`. A transfer occurs when `in_valid && in_ready`.
- `tw_index = en ? in_index : s1_index`. This is a combinational mux, so the ROM captures the index in the same edge that S1 captures the operands. During a stall the index is held and the ROM output stays aligned with S1.
- **S1**, on edge with `en`: registers A, B, index and `v1 <= in_valid`. `tw_re`/`tw_im` correspond to S1 on the following cycle.
- **S2**, on edge with `en`:
  - Complex product P = B·W, from four signed 16×16 multiplies.
  - re = b_re·tw_re − b_im·tw_im; im = b_re·tw_im + b_im·tw_re, each held in 33 bits.
  - Round to Q1.15: add 2^14, arithmetic shift right by 15, saturate to [0x8000, 0x7FFF].
  - Registers P and A; `v2 <= v1`.
- **S3**, on edge with `en`:
  - 17-bit sums S = A + P and D = A − P.
  - Scale or saturate per Configuration.
  - Registers X0 = S, X1 = D; `out_valid <= v2`.
- Bubbles (`in_valid` low) propagate as invalid slots. The ROM still loads `in_index`; its output is a don't-care for that slot.
- All index values 0..7 pass through unchanged. The block does no range checking.

## Timing
- Latency: a transfer at edge N produces `out_valid` high after edge N+2. Throughput is one butterfly per clock when `out_ready` is held high.
- Stall: while `out_valid && !out_ready`:
  - All stages hold.
  - `in_ready` is low.
  - Outputs, `tw_index` and ROM data are stable.
- `out_valid` and the output data are stable until accepted.
- Simultaneous accept and present: with `out_valid && out_ready && in_valid`, a new item enters S1 and the output advances in the same edge.
- Reset (async, at any time, including mid-stream):
  - `v1`, `v2` and `out_valid` clear to 0 immediately.
  - All data registers and `s1_index` clear to 0.
  - `in_ready` is 1 after reset, because `en` is true when `out_valid` is 0.
  - `tw_index` follows `in_index` after reset.
  - In-flight items are discarded.

## Configuration
- `FFT_BFLY_SCALE_EN` defined:
  - S and D are scaled by 1/2 with round-half-up: (x + 1) >>> 1 on the 17-bit value.
  - The result always fits in 16 bits, so no saturation is needed.
  - Per-stage scaling keeps the 3-stage, 8-point output within 1/8 of the true DFT.
- Not defined: S and D are saturated to 16 bits, giving 0x7FFF on positive overflow and 0x8000 on negative overflow.

## Structure
- Package `fft_pkg` holds:
  - `DW` and `Q` (15).
  - The rounding constant `ROUND_Q15 = 2^14`.
  - A `cplx_t` typedef (re/im 16-bit signed).
  - The `sat16` saturation function, shared with other FFT stages.
- Sub-module `cmul_q15`: the combinational complex multiplier with rounding and saturation, instantiated in S2 and reusable elsewhere.

## Test plan
- **Index 0, W = 0x7FFF + j0x0000, `out_ready` = 1.** A = 0x4000 + j0, B = 0x2000 + j0 gives P = 0x2000. Response:
  - Unscaled: X0 = 0x6000 + j0, X1 = 0x2000 + j0.
  - Scaled: X0 = 0x3000, X1 = 0x1000.
  - `out_valid` rises 2 edges after the accept.
- **Index 2, W = 0x0000 + j0x8000 (−j).** Same A and B. Response:
  - Unscaled: X0 = 0x4000 + j0xE000, X1 = 0x4000 + j0x2000.
  - `tw_index` = 2 on the accept cycle.
- **Overflow, index 0.** A = B = 0x7000 + j0 gives P = 0x6FFF. Response:
  - Unscaled: X0_re = 0x7FFF (saturated), X1_re = 0x0001.
  - Scaled: X0_re = 0x7000, X1_re = 0x0001.
- **Backpressure.** Stream indices 0, 1, 2, 3 back-to-back and drop `out_ready` for 3 cycles after the first output. Required response:
  - `in_ready` is low during the stall.
  - `tw_index` is held.
  - The outputs are unchanged.
  - After release, the four results arrive in order and each is correct for its own index.
- **Reset mid-stream.** Assert `rst` asynchronously with 2 items in flight. Required response:
  - `out_valid` goes to 0 immediately and all outputs are 0.
  - After release, `in_ready` = 1 and the next item's result appears 2 edges after its accept, uncorrupted.
- **Bubbles.** Alternate `in_valid` 1/0 for 8 cycles. Required response:
  - `out_valid` toggles with the same pattern, delayed by 2 cycles.
  - Every valid output is correct.
